tlc3548_emu: RTL and testbench

Synthesizable responder emulating the ADC serial port (TLC3548-style) at the far end of the acquisition serial link. It decodes command frames from the FPGA-side ADC master, runs emulated conversions into an 8-deep FIFO, raises `int_l` at the FIFO trigger level, and shifts FIFO samples back on read frames. It is used for on-board loopback self-test and as a bench model of the converter.

---
 rtl/tlc_emu_pkg.sv | 27 ++
 rtl/emu_fifo.sv | 105 ++++++++++
 rtl/tlc3548_emu.sv | 219 +++++++++++++++++++++
 tb/tb_tlc3548_emu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_emu_pkg.sv
// tlc_emu_pkg: shared definitions for the TLC3548-style serial-port emulator.
//   - command opcodes decoded from cmd[15:12]
//   - frame FSM state encoding
//   - sample width
//   - LFSR seed, taps and step function (used only when TLC_EMU_LFSR_EN is defined)
package tlc_emu_pkg;

  localparam logic [3:0] OP_CFG = 4'hA;
  localparam logic [3:0] OP_RD  = 4'hE;

  localparam int SAMPLE_W = 14;

  // x^16 + x^14 + x^13 + x^11 + 1, taken from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } frame_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/emu_fifo.sv
// emu_fifo: synchronous sample FIFO with speculative pop.
//   clk, rst        : clock, synchronous active-low reset
//   push_i/_data_i  : write one sample (dropped when full, unless a commit frees a slot)
//   pop_i           : speculative pop at frame start; head_o is the word handed out
//   commit_i        : the speculative pop is real, retire the head
//   restore_i       : the speculative pop is cancelled, head stays in place
//   flush_i         : empty the FIFO and cancel any pending pop
//   head_o          : current head (0 when empty)
//   cnt_o/cnt_nxt_o : committed occupancy, and its value after this edge
//   drop_o          : push lost because the FIFO was full
//   udf_o           : a committed pop found the FIFO empty
// The restore register is the pending-pop record (pend_q / pend_empty_q):
// the read pointer only moves on commit, so restoring just forgets the record.
module emu_fifo
  import tlc_emu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  input  logic         commit_i,
  input  logic         restore_i,
  input  logic         flush_i,
  output logic [W-1:0] head_o,
  output logic [3:0]   cnt_o,
  output logic [3:0]   cnt_nxt_o,
  output logic         drop_o,
  output logic         udf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d, pend_empty_q, pend_empty_d;
  logic          full, empty, do_push, do_commit;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == 4'd0);
  assign head_o    = empty ? '0 : mem_q[rd_q];
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

  always_comb begin
    do_commit    = commit_i && pend_q && !pend_empty_q;
    // a commit in the same cycle frees the slot, so a full FIFO still accepts
    do_push      = push_i && !flush_i && (!full || do_commit);
    drop_o       = push_i && !flush_i && !do_push;
    udf_o        = commit_i && pend_q && pend_empty_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_empty_d = pend_empty_q;
    if (flush_i) begin
      wr_d         = '0;
      rd_d         = '0;
      cnt_d        = '0;
      pend_d       = 1'b0;
      pend_empty_d = 1'b0;
    end else begin
      if (do_push)   wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
      if (do_commit) rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
      case ({do_push, do_commit})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (pop_i) begin
        pend_d       = 1'b1;
        pend_empty_d = empty;
      end else if (commit_i || restore_i) begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_empty_q <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_empty_q <= pend_empty_d;
    end
  end

endmodule

// File: rtl/tlc3548_emu.sv
// tlc3548_emu: responder emulating a TLC3548-style ADC serial port.
//   clk        : system and serial clock
//   rst        : synchronous active-low reset
//   cs_l       : chip select, active low (high: fs ignored, sdo held 0)
//   fs         : frame sync pulse; sdi carries 16 command bits MSB first after it
//   sdi / sdo  : command in / 14-bit sample out, MSB first
//   int_l      : FIFO-trigger interrupt, active low
//   cfg_reg    : last configuration word
//   fifo_cnt   : FIFO occupancy
//   ovf / udf  : sticky overflow / underflow, cleared by clr_flags
// Optional build macro TLC_EMU_LFSR_EN: XOR sample bits [3:0] with an LFSR.
//
// state  | meaning
// IDLE   | waiting for fs with cs_l low
// SHIFT  | shifting in 16 command bits; fs here restarts the frame
// DECODE | one cycle acting on cmd[15:12], then back to IDLE
module tlc3548_emu
  import tlc_emu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_TRIG   = 8,
  parameter int CONV_CYCLES = 10,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_l,
  input  logic        fs,
  input  logic        sdi,
  output logic        sdo,
  output logic        int_l,
  output logic [11:0] cfg_reg,
  output logic [3:0]  fifo_cnt,
  output logic        ovf,
  output logic        udf,
  input  logic        clr_flags
);

  localparam logic [4:0] BIT_LAST  = 5'(FRAME_BITS - 1);
  localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);
  localparam logic [3:0] TRIG_C    = 4'(FIFO_TRIG);

  frame_state_e        state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [15:0]         cmd_q, cmd_d;
  logic [2:0]          chan_q, chan_d;
  logic                conv_busy_q, conv_busy_d;
  logic [7:0]          conv_cnt_q, conv_cnt_d;
  logic [10:0]         seq_q [8];
  logic [10:0]         seq_d [8];
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic                sdo_q, sdo_d, int_l_q, int_l_d, armed_q, armed_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic [11:0]         cfg_q, cfg_d;

  logic                fs_v, frame_start, dec, dec_chsel, dec_cfg, dec_rd, conv_push;
  logic [3:0]          op;
  logic [SAMPLE_W-1:0] sample, head;
  logic [3:0]          cnt, cnt_nxt;
  logic                fifo_drop, fifo_udf;

  assign fs_v        = fs && !cs_l;
  // a frame start always pops speculatively; DECODE ignores fs
  assign frame_start = fs_v && (state_q != DECODE);
  assign op          = cmd_q[15:12];
  assign dec         = (state_q == DECODE);
  assign dec_chsel   = dec && !op[3];
  assign dec_cfg     = dec && (op == OP_CFG);
  assign dec_rd      = dec && (op == OP_RD);
  // a new channel select in the terminal cycle aborts the old conversion
  assign conv_push   = conv_busy_q && (conv_cnt_q == 8'd0) && !dec_chsel;

`ifdef TLC_EMU_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = conv_push ? lfsr_next(lfsr_q) : lfsr_q;
  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end
  assign sample = {chan_q, seq_q[chan_q]} ^ {10'd0, lfsr_q[3:0]};
`else
  assign sample = {chan_q, seq_q[chan_q]};
`endif

  emu_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (SAMPLE_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (conv_push),
    .push_data_i(sample),
    .pop_i      (frame_start),
    .commit_i   (dec_rd),
    .restore_i  (dec && !dec_rd),
    .flush_i    (dec_cfg),
    .head_o     (head),
    .cnt_o      (cnt),
    .cnt_nxt_o  (cnt_nxt),
    .drop_o     (fifo_drop),
    .udf_o      (fifo_udf)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    case (state_q)
      IDLE: begin
        if (fs_v) begin
          state_d   = SHIFT;
          bit_cnt_d = BIT_LAST;
          cmd_d     = '0;
        end
      end
      SHIFT: begin
        if (fs_v) begin
          bit_cnt_d = BIT_LAST;
          cmd_d     = '0;
        end else begin
          cmd_d = {cmd_q[14:0], sdi};
          if (bit_cnt_q == 5'd0) state_d = DECODE;
          else                   bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chan_d      = chan_q;
    conv_busy_d = conv_busy_q;
    conv_cnt_d  = conv_cnt_q;
    seq_d       = seq_q;
    cfg_d       = cfg_q;
    sh_d        = {sh_q[SAMPLE_W-2:0], 1'b0};
    sdo_d       = sh_q[SAMPLE_W-1];
    int_l_d     = int_l_q;
    armed_d     = armed_q;
    ovf_d       = (ovf_q && !clr_flags) || fifo_drop;
    udf_d       = (udf_q && !clr_flags) || fifo_udf;

    if (dec_chsel) begin
      chan_d      = op[2:0];
      conv_busy_d = 1'b1;
      conv_cnt_d  = CONV_LOAD;
    end else if (conv_push) begin
      conv_busy_d = 1'b0;
    end else if (conv_busy_q) begin
      conv_cnt_d = conv_cnt_q - 1'b1;
    end

    // the sequence number is consumed even when the sample is dropped
    if (conv_push) seq_d[chan_q] = seq_q[chan_q] + 1'b1;

    if (dec_cfg) cfg_d = cmd_q[11:0];

    if (frame_start) begin
      sdo_d = head[SAMPLE_W-1];
      sh_d  = {head[SAMPLE_W-2:0], 1'b0};
    end
    if (cs_l) sdo_d = 1'b0;

    if (dec_rd) begin
      int_l_d = 1'b1;
      armed_d = 1'b0;
    end else if (dec_cfg) begin
      int_l_d = 1'b1;
      armed_d = 1'b1;
    end else if (cnt_nxt < TRIG_C) begin
      armed_d = 1'b1;
    end else if (armed_q) begin
      int_l_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      chan_q      <= '0;
      conv_busy_q <= 1'b0;
      conv_cnt_q  <= '0;
      for (int i = 0; i < 8; i++) seq_q[i] <= '0;
      sh_q        <= '0;
      sdo_q       <= 1'b0;
      int_l_q     <= 1'b1;
      armed_q     <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      cfg_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      chan_q      <= chan_d;
      conv_busy_q <= conv_busy_d;
      conv_cnt_q  <= conv_cnt_d;
      seq_q       <= seq_d;
      sh_q        <= sh_d;
      sdo_q       <= sdo_d;
      int_l_q     <= int_l_d;
      armed_q     <= armed_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      cfg_q       <= cfg_d;
    end
  end

  assign sdo      = sdo_q;
  assign int_l    = int_l_q;
  assign cfg_reg  = cfg_q;
  assign fifo_cnt = cnt;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_tlc3548_emu.sv
// Directed bench for tlc3548_emu. Inputs change and outputs are sampled on the
// falling edge; cycle F is the cycle in which fs is high.
module tb_tlc3548_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs_l = 1'b0;
  logic        fs = 1'b0;
  logic        sdi = 1'b0;
  logic        clr_flags = 1'b0;
  logic        sdo, int_l, ovf, udf;
  logic [11:0] cfg_reg;
  logic [3:0]  fifo_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tlc3548_emu dut (
    .clk      (clk),
    .rst      (rst),
    .cs_l     (cs_l),
    .fs       (fs),
    .sdi      (sdi),
    .sdo      (sdo),
    .int_l    (int_l),
    .cfg_reg  (cfg_reg),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf),
    .udf      (udf),
    .clr_flags(clr_flags)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // fs in cycle F, command bits in F+1..F+nbits; sdo captured in F+1..F+14.
  // Returns at the falling edge of F+nbits.
  task automatic send_bits(input logic [15:0] cmd, input int nbits, output logic [13:0] rx);
    rx = '0;
    @(negedge clk);
    fs  = 1'b1;
    sdi = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i < 14) rx[13-i] = sdo;
      fs  = 1'b0;
      sdi = cmd[15-i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++; if (sdo !== 1'b0)       begin n_fail++; $display("FAIL %s_sdo: got %b want 0", tag, sdo); end
    n_tests++; if (int_l !== 1'b1)     begin n_fail++; $display("FAIL %s_int_l: got %b want 1", tag, int_l); end
    n_tests++; if (cfg_reg !== 12'h0)  begin n_fail++; $display("FAIL %s_cfg: got %h want 000", tag, cfg_reg); end
    n_tests++; if (fifo_cnt !== 4'd0)  begin n_fail++; $display("FAIL %s_cnt: got %0d want 0", tag, fifo_cnt); end
    n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL %s_ovf: got %b want 0", tag, ovf); end
    n_tests++; if (udf !== 1'b0)       begin n_fail++; $display("FAIL %s_udf: got %b want 0", tag, udf); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_cfg();
    logic [13:0] rx;
    send_bits(16'hA240, 16, rx);
    cyc(2);
    n_tests++; if (cfg_reg !== 12'h240) begin n_fail++; $display("FAIL cfg_write: got %h want 240", cfg_reg); end
    n_tests++; if (fifo_cnt !== 4'd0)   begin n_fail++; $display("FAIL cfg_cnt: got %0d want 0", fifo_cnt); end
    n_tests++; if (int_l !== 1'b1)      begin n_fail++; $display("FAIL cfg_int_l: got %b want 1", int_l); end
  endtask

  task automatic test_chsel();
    logic [13:0] rx;
    logic [15:0] c;
    send_bits(16'h0000, 16, rx);
    cyc(11);
    n_tests++; if (fifo_cnt !== 4'd0) begin n_fail++; $display("FAIL conv_lat_f27: got %0d want 0", fifo_cnt); end
    cyc(1);
    n_tests++; if (fifo_cnt !== 4'd1) begin n_fail++; $display("FAIL conv_lat_f28: got %0d want 1", fifo_cnt); end
    for (int ch = 1; ch < 8; ch++) begin
      c = {1'b0, 3'(ch), 12'h000};
      send_bits(c, 16, rx);
      if (ch < 7) cyc(7);
    end
    cyc(11);
    n_tests++; if (fifo_cnt !== 4'd7) begin n_fail++; $display("FAIL chsel_cnt7: got %0d want 7", fifo_cnt); end
    n_tests++; if (int_l !== 1'b1)    begin n_fail++; $display("FAIL chsel_int_pre: got %b want 1", int_l); end
    cyc(1);
    n_tests++; if (fifo_cnt !== 4'd8) begin n_fail++; $display("FAIL chsel_cnt8: got %0d want 8", fifo_cnt); end
    n_tests++; if (int_l !== 1'b0)    begin n_fail++; $display("FAIL chsel_int_fall: got %b want 0", int_l); end
    n_tests++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL chsel_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_read();
    logic [13:0] rx, exp;
    for (int k = 0; k < 8; k++) begin
      exp = {3'(k), 11'd0};
      send_bits(16'hE000, 16, rx);
      n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL read_sdo%0d: got %h want %h", k, rx, exp); end
      cyc(1);
      if (k == 0) begin
        n_tests++; if (int_l !== 1'b0) begin n_fail++; $display("FAIL read_int_f17: got %b want 0", int_l); end
      end
      cyc(1);
      if (k == 0) begin
        n_tests++; if (int_l !== 1'b1)    begin n_fail++; $display("FAIL read_int_f18: got %b want 1", int_l); end
        n_tests++; if (fifo_cnt !== 4'd7) begin n_fail++; $display("FAIL read_cnt_f18: got %0d want 7", fifo_cnt); end
      end
    end
    n_tests++; if (fifo_cnt !== 4'd0) begin n_fail++; $display("FAIL read_cnt_end: got %0d want 0", fifo_cnt); end
    n_tests++; if (udf !== 1'b0)      begin n_fail++; $display("FAIL read_udf: got %b want 0", udf); end
  endtask

  task automatic test_underflow();
    logic [13:0] rx;
    send_bits(16'hE000, 16, rx);
    n_tests++; if (rx !== 14'h0000) begin n_fail++; $display("FAIL udf_sdo: got %h want 0000", rx); end
    cyc(2);
    n_tests++; if (udf !== 1'b1)      begin n_fail++; $display("FAIL udf_set: got %b want 1", udf); end
    n_tests++; if (fifo_cnt !== 4'd0) begin n_fail++; $display("FAIL udf_cnt: got %0d want 0", fifo_cnt); end
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    cyc(1);
    n_tests++; if (udf !== 1'b0) begin n_fail++; $display("FAIL udf_clr: got %b want 0", udf); end
  endtask

  task automatic test_overflow();
    logic [13:0] rx, exp;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    for (int k = 0; k < 9; k++) begin
      send_bits(16'h3000, 16, rx);
      cyc(7);
    end
    n_tests++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL ovf_pre: got %b want 0", ovf); end
    n_tests++; if (fifo_cnt !== 4'd8) begin n_fail++; $display("FAIL ovf_full: got %0d want 8", fifo_cnt); end
    cyc(5);
    n_tests++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end
    n_tests++; if (fifo_cnt !== 4'd8) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 8", fifo_cnt); end
    n_tests++; if (int_l !== 1'b0)    begin n_fail++; $display("FAIL ovf_int: got %b want 0", int_l); end
    send_bits(16'hE000, 16, rx);
    n_tests++; if (rx !== 14'h1800) begin n_fail++; $display("FAIL ovf_rd0: got %h want 1800", rx); end
    cyc(2);
    send_bits(16'h3000, 16, rx);
    cyc(12);
    n_tests++; if (fifo_cnt !== 4'd8) begin n_fail++; $display("FAIL rearm_cnt: got %0d want 8", fifo_cnt); end
    n_tests++; if (int_l !== 1'b0)    begin n_fail++; $display("FAIL rearm_int: got %b want 0", int_l); end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? 14'h1801 + 14'(k) : 14'h1809;
      send_bits(16'hE000, 16, rx);
      n_tests++; if (rx !== exp) begin n_fail++; $display("FAIL ovf_rd%0d: got %h want %h", k + 1, rx, exp); end
      cyc(2);
    end
    n_tests++; if (fifo_cnt !== 4'd0) begin n_fail++; $display("FAIL ovf_drain: got %0d want 0", fifo_cnt); end
    n_tests++; if (ovf !== 1'b1)      begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    cyc(1);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf); end
  endtask

  task automatic test_abort_reset();
    logic [13:0] rx;
    send_bits(16'hA5FF, 4, rx);
    send_bits(16'hA123, 16, rx);
    cyc(2);
    n_tests++; if (cfg_reg !== 12'h123) begin n_fail++; $display("FAIL abort_cfg: got %h want 123", cfg_reg); end
    cs_l = 1'b1;
    send_bits(16'hA777, 16, rx);
    cyc(2);
    cs_l = 1'b0;
    n_tests++; if (cfg_reg !== 12'h123) begin n_fail++; $display("FAIL cs_ignore: got %h want 123", cfg_reg); end
    send_bits(16'h5000, 16, rx);
    cyc(5);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(20);
    check_reset_outputs("midconv_rst");
  endtask

  initial begin
    test_reset();
    test_cfg();
    test_chsel();
    test_read();
    test_underflow();
    test_overflow();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
